// File: rtl/lc4_regfile_mp.sv
// lc4_regfile_mp: multi-port LC4 register file with scoreboard and one-deep checkpoint.
// NW write ports (highest index wins on conflict), NR combinational read ports with
// same-cycle write bypass, per-register busy bits, and a shadow bank for rollback.
module lc4_regfile_mp #(
  parameter int n     = 16,
  parameter int NREGS = 8,
  parameter int NR    = 4,
  parameter int NW    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            gwe,
  input  logic [NR*$clog2(NREGS)-1:0]     i_rsel,
  output logic [NR*n-1:0]                 o_rdata,
  output logic [NR-1:0]                   o_rbusy,
  input  logic [NW-1:0]                   i_we,
  input  logic [NW*$clog2(NREGS)-1:0]     i_wsel,
  input  logic [NW*n-1:0]                 i_wdata,
  input  logic [NW-1:0]                   i_rsv,
  input  logic [NW*$clog2(NREGS)-1:0]     i_rsv_sel,
  input  logic                            i_ckpt_save,
  input  logic                            i_ckpt_restore,
  output logic [NREGS-1:0]                o_busy,
  output logic                            o_ckpt_valid,
  output logic                            o_ckpt_err
);

  localparam int AW = $clog2(NREGS);

  logic [n-1:0]     regs_reg   [NREGS];
  logic [n-1:0]     shadow_reg [NREGS];
  logic [n-1:0]     regs_next  [NREGS];
  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] rsv_hit;
  logic             ckpt_valid_reg;
  logic             ckpt_err_reg;
  logic             restore_ok;

  // A restore only acts when a snapshot exists; otherwise it is flagged as an error.
  assign restore_ok = i_ckpt_restore & ckpt_valid_reg;

  // Decode write/reserve ports per register; later ports overwrite earlier ones so the
  // highest-index write wins. regs_next doubles as the bypassed read value.
  always_comb begin
    for (int k = 0; k < NREGS; k++) begin
      wr_hit[k]    = 1'b0;
      rsv_hit[k]   = 1'b0;
      regs_next[k] = regs_reg[k];
      for (int p = 0; p < NW; p++) begin
        if (i_we[p] && (i_wsel[p*AW +: AW] == AW'(k))) begin
          wr_hit[k]    = 1'b1;
          regs_next[k] = i_wdata[p*n +: n];
        end
        if (i_rsv[p] && (i_rsv_sel[p*AW +: AW] == AW'(k))) begin
          rsv_hit[k] = 1'b1;
        end
      end
    end
  end

  // A new reservation beats a completing write: the newer producer keeps the bit set.
  assign busy_next = rsv_hit | (busy_reg & ~wr_hit);

  // Read ports: bypassed data, and busy masked by any write arriving this cycle.
  for (genvar gi = 0; gi < NR; gi++) begin : g_read
    logic [AW-1:0] rsel;
    assign rsel                 = i_rsel[gi*AW +: AW];
    assign o_rdata[gi*n +: n]   = regs_next[rsel];
    assign o_rbusy[gi]          = busy_reg[rsel] & ~wr_hit[rsel];
  end

  // Architectural state, scoreboard and checkpoint; everything holds while gwe is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_reg[k]   <= '0;
        shadow_reg[k] <= '0;
      end
      busy_reg       <= '0;
      ckpt_valid_reg <= 1'b0;
      ckpt_err_reg   <= 1'b0;
    end else if (gwe) begin
      ckpt_err_reg <= i_ckpt_restore & ~ckpt_valid_reg;
      if (restore_ok) begin
        // Rollback discards this cycle's writes/reserves and any concurrent save.
        for (int k = 0; k < NREGS; k++) begin
          regs_reg[k] <= shadow_reg[k];
        end
        busy_reg       <= '0;
        ckpt_valid_reg <= 1'b0;
      end else begin
        for (int k = 0; k < NREGS; k++) begin
          regs_reg[k] <= regs_next[k];
        end
        busy_reg <= busy_next;
        if (i_ckpt_save && !i_ckpt_restore) begin
          for (int k = 0; k < NREGS; k++) begin
            shadow_reg[k] <= regs_next[k];
          end
          ckpt_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign o_busy       = busy_reg;
  assign o_ckpt_valid = ckpt_valid_reg;
  assign o_ckpt_err   = ckpt_err_reg;

endmodule

// File: tb/tb_lc4_regfile_mp.sv
// Directed testbench for lc4_regfile_mp (n=16, NREGS=8, NR=4, NW=2).
module tb_lc4_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic [11:0] i_rsel;
  logic [63:0] o_rdata;
  logic [3:0]  o_rbusy;
  logic [1:0]  i_we;
  logic [5:0]  i_wsel;
  logic [31:0] i_wdata;
  logic [1:0]  i_rsv;
  logic [5:0]  i_rsv_sel;
  logic        i_ckpt_save;
  logic        i_ckpt_restore;
  logic [7:0]  o_busy;
  logic        o_ckpt_valid;
  logic        o_ckpt_err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  lc4_regfile_mp #(.n(16), .NREGS(8), .NR(4), .NW(2)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_rsel(i_rsel), .o_rdata(o_rdata), .o_rbusy(o_rbusy),
    .i_we(i_we), .i_wsel(i_wsel), .i_wdata(i_wdata),
    .i_rsv(i_rsv), .i_rsv_sel(i_rsv_sel),
    .i_ckpt_save(i_ckpt_save), .i_ckpt_restore(i_ckpt_restore),
    .o_busy(o_busy), .o_ckpt_valid(o_ckpt_valid), .o_ckpt_err(o_ckpt_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    gwe = 1'b1; i_we = '0; i_wsel = '0; i_wdata = '0;
    i_rsv = '0; i_rsv_sel = '0; i_ckpt_save = 1'b0; i_ckpt_restore = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_rsel(input int r, input int k);
    i_rsel[r*3 +: 3] = 3'(k);
  endtask

  task automatic set_write(input int p, input int k, input logic [15:0] d);
    i_we[p] = 1'b1; i_wsel[p*3 +: 3] = 3'(k); i_wdata[p*16 +: 16] = d;
  endtask

  task automatic set_rsv(input int p, input int k);
    i_rsv[p] = 1'b1; i_rsv_sel[p*3 +: 3] = 3'(k);
  endtask

  function automatic logic [15:0] rd(input int r);
    return o_rdata[r*16 +: 16];
  endfunction

  task automatic test_reset();
    rst = 1'b0; clear_inputs(); i_rsel = '0;
    for (int r = 0; r < 4; r++) set_rsel(r, r);
    step(); step();
    chk_cnt++; if (o_busy !== 8'h00) $display("FAIL reset_busy got %h want 00", o_busy); else pass_cnt++;
    chk_cnt++; if (o_ckpt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_ckpt_valid); else pass_cnt++;
    chk_cnt++; if (o_ckpt_err !== 1'b0) $display("FAIL reset_err got %b want 0", o_ckpt_err); else pass_cnt++;
    chk_cnt++; if (o_rdata !== 64'h0) $display("FAIL reset_rdata got %h want 0", o_rdata); else pass_cnt++;
    rst = 1'b1;
    step();
    $display("test_reset done");
  endtask

  task automatic test_write_bypass();
    clear_inputs(); set_write(0, 3, 16'h1234); set_rsel(0, 3); #1;
    chk_cnt++; if (rd(0) !== 16'h1234) $display("FAIL bypass_r3 got %h want 1234", rd(0)); else pass_cnt++;
    step(); clear_inputs(); #1;
    chk_cnt++; if (rd(0) !== 16'h1234) $display("FAIL stored_r3 got %h want 1234", rd(0)); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      set_rsel(1, k); #1;
      chk_cnt++;
      if (rd(1) !== ((k == 3) ? 16'h1234 : 16'h0000))
        $display("FAIL stored_r%0d got %h want %h", k, rd(1), (k == 3) ? 16'h1234 : 16'h0000);
      else pass_cnt++;
    end
    $display("test_write_bypass done");
  endtask

  task automatic test_conflict();
    clear_inputs(); set_write(0, 5, 16'hAAAA); set_write(1, 5, 16'h5555); set_rsel(0, 5); #1;
    chk_cnt++; if (rd(0) !== 16'h5555) $display("FAIL conflict_bypass got %h want 5555", rd(0)); else pass_cnt++;
    step(); clear_inputs(); #1;
    chk_cnt++; if (rd(0) !== 16'h5555) $display("FAIL conflict_stored got %h want 5555", rd(0)); else pass_cnt++;
    $display("test_conflict done");
  endtask

  task automatic test_scoreboard();
    clear_inputs(); set_rsv(0, 2); set_rsel(0, 2);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_busy !== 8'h04) $display("FAIL rsv_busy got %h want 04", o_busy); else pass_cnt++;
    chk_cnt++; if (o_rbusy[0] !== 1'b1) $display("FAIL rbusy_pending got %b want 1", o_rbusy[0]); else pass_cnt++;
    set_write(0, 2, 16'h2222); #1;
    chk_cnt++; if (o_rbusy[0] !== 1'b0) $display("FAIL rbusy_write_cycle got %b want 0", o_rbusy[0]); else pass_cnt++;
    chk_cnt++; if (rd(0) !== 16'h2222) $display("FAIL r2_bypass got %h want 2222", rd(0)); else pass_cnt++;
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_busy !== 8'h00) $display("FAIL busy_cleared got %h want 00", o_busy); else pass_cnt++;
    set_rsv(1, 2); set_write(0, 2, 16'h3333);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_busy !== 8'h04) $display("FAIL rsv_and_write got %h want 04", o_busy); else pass_cnt++;
    chk_cnt++; if (rd(0) !== 16'h3333) $display("FAIL r2_stored got %h want 3333", rd(0)); else pass_cnt++;
    set_write(1, 2, 16'h3333);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_busy !== 8'h00) $display("FAIL busy_recleared got %h want 00", o_busy); else pass_cnt++;
    $display("test_scoreboard done");
  endtask

  task automatic test_gwe_hold();
    clear_inputs(); gwe = 1'b0;
    set_write(0, 1, 16'hBEEF); set_rsv(1, 7); i_ckpt_save = 1'b1; set_rsel(0, 1); #1;
    chk_cnt++; if (rd(0) !== 16'hBEEF) $display("FAIL gwe0_bypass got %h want beef", rd(0)); else pass_cnt++;
    step(); clear_inputs(); #1;
    chk_cnt++; if (rd(0) !== 16'h0000) $display("FAIL gwe0_r1 got %h want 0000", rd(0)); else pass_cnt++;
    chk_cnt++; if (o_busy !== 8'h00) $display("FAIL gwe0_busy got %h want 00", o_busy); else pass_cnt++;
    chk_cnt++; if (o_ckpt_valid !== 1'b0) $display("FAIL gwe0_valid got %b want 0", o_ckpt_valid); else pass_cnt++;
    $display("test_gwe_hold done");
  endtask

  task automatic test_checkpoint();
    clear_inputs(); set_write(0, 1, 16'h0011); i_ckpt_save = 1'b1; set_rsel(0, 1); set_rsel(1, 3);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_ckpt_valid !== 1'b1) $display("FAIL save_valid got %b want 1", o_ckpt_valid); else pass_cnt++;
    set_write(0, 1, 16'h0099); set_rsv(0, 4);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_busy !== 8'h10) $display("FAIL pre_restore_busy got %h want 10", o_busy); else pass_cnt++;
    chk_cnt++; if (rd(0) !== 16'h0099) $display("FAIL pre_restore_r1 got %h want 0099", rd(0)); else pass_cnt++;
    i_ckpt_restore = 1'b1; set_write(0, 1, 16'h0AAA); set_rsv(1, 6); #1;
    chk_cnt++; if (rd(0) !== 16'h0AAA) $display("FAIL restore_cycle_read got %h want 0aaa", rd(0)); else pass_cnt++;
    step(); clear_inputs(); #1;
    chk_cnt++; if (rd(0) !== 16'h0011) $display("FAIL restored_r1 got %h want 0011", rd(0)); else pass_cnt++;
    chk_cnt++; if (rd(1) !== 16'h1234) $display("FAIL restored_r3 got %h want 1234", rd(1)); else pass_cnt++;
    chk_cnt++; if (o_busy !== 8'h00) $display("FAIL restored_busy got %h want 00", o_busy); else pass_cnt++;
    chk_cnt++; if (o_ckpt_valid !== 1'b0) $display("FAIL restored_valid got %b want 0", o_ckpt_valid); else pass_cnt++;
    chk_cnt++; if (o_ckpt_err !== 1'b0) $display("FAIL restored_err got %b want 0", o_ckpt_err); else pass_cnt++;
    $display("test_checkpoint done");
  endtask

  task automatic test_error();
    clear_inputs(); i_ckpt_restore = 1'b1; set_write(0, 6, 16'h7777); set_rsel(0, 6);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_ckpt_err !== 1'b1) $display("FAIL err_pulse got %b want 1", o_ckpt_err); else pass_cnt++;
    chk_cnt++; if (rd(0) !== 16'h7777) $display("FAIL err_r6 got %h want 7777", rd(0)); else pass_cnt++;
    step();
    chk_cnt++; if (o_ckpt_err !== 1'b0) $display("FAIL err_clear got %b want 0", o_ckpt_err); else pass_cnt++;
    // Take a snapshot with R7=0x0707, then save+restore together while writing R7.
    set_write(0, 7, 16'h0707); i_ckpt_save = 1'b1; set_rsel(0, 7);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_ckpt_valid !== 1'b1) $display("FAIL save2_valid got %b want 1", o_ckpt_valid); else pass_cnt++;
    set_write(0, 7, 16'hFFFF); i_ckpt_save = 1'b1; i_ckpt_restore = 1'b1;
    step(); clear_inputs(); #1;
    chk_cnt++; if (rd(0) !== 16'h0707) $display("FAIL save_restore_r7 got %h want 0707", rd(0)); else pass_cnt++;
    chk_cnt++; if (o_ckpt_valid !== 1'b0) $display("FAIL save_restore_valid got %b want 0", o_ckpt_valid); else pass_cnt++;
    chk_cnt++; if (o_ckpt_err !== 1'b0) $display("FAIL save_restore_err got %b want 0", o_ckpt_err); else pass_cnt++;
    $display("test_error done");
  endtask

  task automatic test_back_to_back();
    clear_inputs(); set_write(1, 0, 16'h0001); set_rsel(0, 0);
    step(); clear_inputs(); set_write(0, 0, 16'h0002); set_rsv(1, 0); #1;
    chk_cnt++; if (rd(0) !== 16'h0002) $display("FAIL b2b_bypass got %h want 0002", rd(0)); else pass_cnt++;
    step(); clear_inputs(); #1;
    chk_cnt++; if (rd(0) !== 16'h0002) $display("FAIL b2b_r0 got %h want 0002", rd(0)); else pass_cnt++;
    chk_cnt++; if (o_busy !== 8'h01) $display("FAIL b2b_busy got %h want 01", o_busy); else pass_cnt++;
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    clear_inputs(); i_ckpt_save = 1'b1; set_rsv(0, 5); set_rsel(0, 0);
    step(); clear_inputs(); #1;
    chk_cnt++; if (o_ckpt_valid !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", o_ckpt_valid); else pass_cnt++;
    #2 rst = 1'b0; #1;
    chk_cnt++; if (o_ckpt_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", o_ckpt_valid); else pass_cnt++;
    chk_cnt++; if (o_busy !== 8'h00) $display("FAIL mid_busy got %h want 00", o_busy); else pass_cnt++;
    chk_cnt++; if (rd(0) !== 16'h0000) $display("FAIL mid_r0 got %h want 0000", rd(0)); else pass_cnt++;
    step(); rst = 1'b1; step();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_conflict();
    test_scoreboard();
    test_gwe_hold();
    test_checkpoint();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lc4_regfile_mp.md
Name: lc4_regfile_mp

Overview:
- Parametrised multi-port register file for the LC4 superscalar pipeline, generalising the two-pipe file to NW write ports, NR read ports and NREGS registers.
- Adds a per-register scoreboard (reserve/release busy bits) for in-flight producers.
- Adds a one-deep checkpoint bank, so the pipeline can snapshot architectural state and roll back on a flush.
- Sits in decode/writeback. Read ports feed decode and operand fetch; write ports come from the writeback of each pipe.

Parameters:
- n, 16, data width
- NREGS, 8, number of registers (power of two, >=2); localparam AW = clog2(NREGS)
- NR, 4, number of read ports
- NW, 2, number of write ports (also number of reservation ports)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- gwe  input  1  global write enable; when 0, no architectural state changes
- i_rsel  input  NR*AW  read selectors, port r at [r*AW +: AW]
- o_rdata  output  NR*n  read data, port r at [r*n +: n]
- o_rbusy  output  NR  busy flag of the register selected on each read port
- i_we  input  NW  write enables
- i_wsel  input  NW*AW  write register selectors
- i_wdata  input  NW*n  write data
- i_rsv  input  NW  reserve strobes (mark destination busy)
- i_rsv_sel  input  NW*AW  reserve register selectors
- i_ckpt_save  input  1  snapshot request
- i_ckpt_restore  input  1  rollback request
- o_busy  output  NREGS  registered scoreboard vector
- o_ckpt_valid  output  1  shadow bank holds a valid snapshot
- o_ckpt_err  output  1  one-cycle pulse: restore requested with no valid snapshot

Behaviour:
- Reset (rst=0, async): all registers, shadow bank, o_busy, o_ckpt_valid and o_ckpt_err clear to 0.
- gwe=0: registers, shadow, busy, ckpt_valid and ckpt_err hold. Combinational reads and bypass still operate.

Write rules:
- Register k is written when any port p has i_we[p]=1 and i_wsel[p]=k.
- If several ports target the same register, the highest-index port wins.
- Writes take effect at the next rising edge (gwe=1).

Read rules (combinational, zero latency):
- o_rdata[r] returns the winning same-cycle write data if any enabled write targets i_rsel[r]; otherwise it returns the stored value. Bypass is independent of gwe.
- o_rbusy[r] = busy[i_rsel[r]] AND NOT (any enabled write to that register this cycle).

Scoreboard (next-state per register k):
- Set if any i_rsv[p] targets k.
- Otherwise cleared if any enabled write targets k.
- Otherwise held.
- A reserve and a write to the same register in the same cycle leave it busy (the new producer wins).

Checkpoint:
- Save (save=1, restore=0): the shadow bank captures the post-write next-state of every register (this cycle's writes included). o_ckpt_valid goes to 1 next cycle. Saving again overwrites the snapshot.
- Restore with o_ckpt_valid=1:
  - Next cycle, registers equal the shadow bank and all busy bits are 0.
  - Same-cycle writes and reserves are discarded.
  - o_ckpt_valid clears; the shadow bank is unchanged.
  - Reads in the restore cycle still show pre-restore bypassed values.
- Restore with o_ckpt_valid=0: ignored; normal writes and reserves proceed; o_ckpt_err=1 for exactly one cycle.
- Save and restore in the same cycle: restore wins and the save is dropped.
- o_ckpt_err is a registered pulse, 0 in every other cycle.
- Reset mid-operation clears everything, including a pending snapshot.
- No reserved register value; register 0 is writable.

Test Plan:
- Reset/bypass: rst low, then high. Write R3=0x1234 on port 0 -> same cycle o_rdata(R3)=0x1234; next cycle stored 0x1234; all other registers 0.
- Write conflict: ports 0 and 1 both write R5 (0xAAAA, 0x5555) -> read returns 0x5555 in the same cycle and after the edge.
- Scoreboard: reserve R2 -> o_busy[2]=1 next cycle. A read of R2 shows o_rbusy=1 until the cycle a write to R2 arrives (o_rbusy=0 that cycle); busy clears after the edge. Reserve and write R2 in the same cycle -> busy stays 1.
- gwe hold: gwe=0 with writes, reserves and save asserted -> registers, busy and ckpt_valid unchanged; bypass still returns the write data.
- Checkpoint: R1=0x0011 with save, then write R1=0x0099 and reserve R4, then restore -> next cycle R1=0x0011, o_busy=0, o_ckpt_valid=0.
- Error path: restore with no snapshot, together with a write R6=0x7777 -> o_ckpt_err pulses one cycle; R6=0x7777 stored. Save and restore in the same cycle with a valid snapshot -> restore wins, shadow unchanged.
